// File: rtl/test_vec_pkg.sv
// Shared constants for the test-vector player: default geometry, vector table, FSM states.
package test_vec_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_DEPTH   = 8;
  localparam int unsigned TABLE_DEPTH = 8;

  // Packed so that VEC_TABLE[i] is entry i; entry 0 is the rightmost element.
  localparam logic [TABLE_DEPTH-1:0][31:0] VEC_TABLE = {
    32'h0000_0000,
    32'h0f06_00f0,
    32'hff05_f00f,
    32'h7f04_700f,
    32'hf003_fff0,
    32'h0402_0202,
    32'h7001_1585,
    32'hff00_f00f
  };

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/test_vec_player_if.sv
// Control and valid/ready stream bundle of the test-vector player.
// TEST_VEC_SIG_EN adds the running signature sig_o.
interface test_vec_player_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 3
);
  logic              start_i;
  logic              loop_i;
  logic              stop_i;
  logic              ready_i;
  logic              valid_o;
  logic [DATA_W-1:0] vec_o;
  logic [IDX_W-1:0]  idx_o;
  logic              busy_o;
  logic              done_o;
`ifdef TEST_VEC_SIG_EN
  logic [DATA_W-1:0] sig_o;
`endif

  modport master (
    input  start_i, loop_i, stop_i, ready_i,
    output valid_o, vec_o, idx_o, busy_o, done_o
`ifdef TEST_VEC_SIG_EN
    , output sig_o
`endif
  );

  modport slave (
    output start_i, loop_i, stop_i, ready_i,
    input  valid_o, vec_o, idx_o, busy_o, done_o
`ifdef TEST_VEC_SIG_EN
    , input sig_o
`endif
  );

endinterface

// File: rtl/test_vec_rom.sv
// Combinational vector table lookup; indices at or past NUM_VEC read as zero.
module test_vec_rom
  import test_vec_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned NUM_VEC = 7,
  parameter int unsigned IDX_W   = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] vec
);

  always_comb begin
    vec = '0;
    for (int i = 0; i < int'(TABLE_DEPTH); i++) begin
      if (i < int'(NUM_VEC) && i < int'(DEPTH) && idx == IDX_W'(i)) begin
        vec = DATA_W'(VEC_TABLE[3'(i)]);
      end
    end
  end

endmodule

// File: rtl/test_vec_player.sv
// Plays table entries 0..NUM_VEC-1 over a valid/ready stream, one-shot or looping.
// Define TEST_VEC_SIG_EN to add a rotate-xor signature of accepted beats on sig_o.
module test_vec_player
  import test_vec_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int unsigned NUM_VEC = 7,
  localparam int unsigned IDX_W  = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  test_vec_player_if.master  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              loop_q, loop_d;
  logic [DATA_W-1:0] vec_q;
  logic [DATA_W-1:0] rom_vec;
  logic              accept;

  assign accept = (state_q == RUN) & bus.ready_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    loop_d  = loop_q;
    case (state_q)
      RUN: begin
        // An accept coinciding with stop still counts, but playback ends either way.
        if (bus.stop_i) begin
          state_d = IDLE;
        end else if (accept) begin
          if (idx_q == LAST_IDX) begin
            if (loop_q) idx_d = '0;
            else        state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        if (bus.start_i) begin
          state_d = RUN;
          idx_d   = '0;
          loop_d  = bus.loop_i;
        end
      end
    endcase
  end

  test_vec_rom #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_rom (
    .idx (idx_d),
    .vec (rom_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      // vec_o tracks idx_o only while playing so both hold their last beat otherwise.
      if (state_d == RUN) vec_q <= rom_vec;
    end
  end

  assign bus.valid_o = (state_q == RUN);
  assign bus.busy_o  = (state_q == RUN);
  assign bus.done_o  = (state_q == DONE);
  assign bus.vec_o   = vec_q;
  assign bus.idx_o   = idx_q;

`ifdef TEST_VEC_SIG_EN
  logic [DATA_W-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if ((state_q != RUN) && bus.start_i) begin
      sig_q <= '0;
    end else if (accept) begin
      sig_q <= ((sig_q << 1) | (sig_q >> (DATA_W - 1))) ^ vec_q;
    end
  end

  assign bus.sig_o = sig_q;
`endif

endmodule
